// File: rtl/piso_serializer.sv
// Parallel-in serial-out shifter: first bit on s_out the cycle after a load, one bit per cycle, frame_done on the last.
// load_ready is high in IDLE or on the last bit (back-to-back frames), and low while flush is high.
module piso_serializer #(
   parameter int WIDTH     = 4,
   parameter int LSB_FIRST = 1
) (
   input  logic             clk,
   input  logic             clear_n,
   input  logic             flush,
   input  logic             load_valid,
   input  logic [WIDTH-1:0] load_data,
   output logic             load_ready,
   output logic             s_out,
   output logic             s_valid,
   output logic             frame_done,
   output logic             busy
);

   localparam int              CW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0]   LAST = CW'(WIDTH - 1);

   typedef enum logic {IDLE, SHIFT} state_t;

   state_t           state;
   logic [CW-1:0]    cnt;
   logic [CW-1:0]    cnt_inc;
   logic [WIDTH-1:0] sreg;

   logic             load_first;
   logic [WIDTH-1:0] load_rest;
   logic             sreg_first;
   logic [WIDTH-1:0] sreg_rest;
   logic             load_fire;

   // sreg holds only the bits not yet on s_out; the bit being driven lives in the s_out flop.
   assign load_first = (LSB_FIRST != 0) ? load_data[0] : load_data[WIDTH-1];
   assign load_rest  = (LSB_FIRST != 0) ? (load_data >> 1) : (load_data << 1);
   assign sreg_first = (LSB_FIRST != 0) ? sreg[0] : sreg[WIDTH-1];
   assign sreg_rest  = (LSB_FIRST != 0) ? (sreg >> 1) : (sreg << 1);
   assign cnt_inc    = cnt + 1'b1;

   assign load_ready = !flush && ((state == IDLE) || (cnt == LAST));
   assign load_fire  = load_valid && load_ready;

   always_ff @(posedge clk or negedge clear_n) begin
      if (!clear_n) begin
         state      <= IDLE;
         cnt        <= '0;
         sreg       <= '0;
         s_out      <= 1'b0;
         s_valid    <= 1'b0;
         frame_done <= 1'b0;
         busy       <= 1'b0;
      end else if (flush) begin
         state      <= IDLE;
         cnt        <= '0;
         sreg       <= '0;
         s_out      <= 1'b0;
         s_valid    <= 1'b0;
         frame_done <= 1'b0;
         busy       <= 1'b0;
      end else if (load_fire) begin
         // Also taken on the last bit of a frame, so the next word follows without a gap.
         state      <= SHIFT;
         cnt        <= '0;
         sreg       <= load_rest;
         s_out      <= load_first;
         s_valid    <= 1'b1;
         frame_done <= (LAST == '0);
         busy       <= 1'b1;
      end else if (state == SHIFT) begin
         if (cnt == LAST) begin
            state      <= IDLE;
            cnt        <= '0;
            sreg       <= '0;
            s_out      <= 1'b0;
            s_valid    <= 1'b0;
            frame_done <= 1'b0;
            busy       <= 1'b0;
         end else begin
            cnt        <= cnt_inc;
            sreg       <= sreg_rest;
            s_out      <= sreg_first;
            frame_done <= (cnt_inc == LAST);
         end
      end
   end

endmodule

// File: tb/tb_piso_serializer.sv
// Drives an LSB-first and an MSB-first serializer with shared stimulus, checked against a bit-queue model.
module tb_piso_serializer;

   localparam int W = 4;

   logic         clk = 1'b0;
   logic         clear_n;
   logic         flush;
   logic         load_valid;
   logic [W-1:0] load_data;

   logic rdy_l, so_l, sv_l, fd_l, bz_l;
   logic rdy_m, so_m, sv_m, fd_m, bz_m;

   always #5 clk = ~clk;

   piso_serializer #(.WIDTH(W), .LSB_FIRST(1)) dut_lsb (
      .clk(clk), .clear_n(clear_n), .flush(flush), .load_valid(load_valid),
      .load_data(load_data), .load_ready(rdy_l), .s_out(so_l), .s_valid(sv_l),
      .frame_done(fd_l), .busy(bz_l)
   );

   piso_serializer #(.WIDTH(W), .LSB_FIRST(0)) dut_msb (
      .clk(clk), .clear_n(clear_n), .flush(flush), .load_valid(load_valid),
      .load_data(load_data), .load_ready(rdy_m), .s_out(so_m), .s_valid(sv_m),
      .frame_done(fd_m), .busy(bz_m)
   );

   int checks = 0;
   int errors = 0;

   // Model: each queue holds the bits still to appear, front = bit currently on s_out.
   bit q_l[$];
   bit q_m[$];

   logic [15:0] obs_l, obs_m;
   logic [3:0]  siso;
   int          nvld, nfd, rdy_hits;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [3:0] exp_vec(input int sz, input bit front);
      return {sz > 0, (sz > 0) ? front : 1'b0, sz == 1, sz > 0};
   endfunction

   task automatic check_outs();
      bit fl, fm;
      fl = (q_l.size() > 0) ? q_l[0] : 1'b0;
      fm = (q_m.size() > 0) ? q_m[0] : 1'b0;
      chk("outs_lsb", {28'd0, sv_l, so_l, fd_l, bz_l}, {28'd0, exp_vec(q_l.size(), fl)});
      chk("outs_msb", {28'd0, sv_m, so_m, fd_m, bz_m}, {28'd0, exp_vec(q_m.size(), fm)});
   endtask

   task automatic clear_obs();
      obs_l = '0; obs_m = '0; siso = '0; nvld = 0; nfd = 0; rdy_hits = 0;
   endtask

   // Called at a falling edge: drive, check ready, advance model at the rising edge, check outputs.
   task automatic cycle(input logic lv, input logic [W-1:0] ld, input logic fl);
      logic exp_rdy;
      load_valid = lv;
      load_data  = ld;
      flush      = fl;
      #1;
      exp_rdy = !fl && (q_l.size() <= 1);
      chk("load_ready_lsb", {31'd0, rdy_l}, {31'd0, exp_rdy});
      chk("load_ready_msb", {31'd0, rdy_m}, {31'd0, exp_rdy});
      if (rdy_l) rdy_hits++;
      @(posedge clk);
      if (fl) begin
         q_l.delete();
         q_m.delete();
      end else begin
         if (q_l.size() > 0) begin
            void'(q_l.pop_front());
            void'(q_m.pop_front());
         end
         if (lv && exp_rdy) begin
            for (int i = 0; i < W; i++) begin
               q_l.push_back(ld[i]);
               q_m.push_back(ld[W-1-i]);
            end
         end
      end
      @(negedge clk);
      check_outs();
      if (sv_l) begin
         obs_l = {obs_l[14:0], so_l};
         siso  = {so_l, siso[3:1]};
         nvld++;
      end
      if (sv_m) obs_m = {obs_m[14:0], so_m};
      if (fd_l) nfd++;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cycle(1'b0, '0, 1'b0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
      $fatal(1, "timeout");
   end

   initial begin
      clear_n = 1'b1; flush = 1'b0; load_valid = 1'b0; load_data = '0;
      #2 clear_n = 1'b0;
      #1 check_outs();
      chk("reset_ready", {31'd0, rdy_l}, 32'd1);
      @(negedge clk);
      clear_n = 1'b1;
      idle(1);

      // Single frame from IDLE, LSB first.
      clear_obs();
      cycle(1'b1, 4'b1011, 1'b0);
      idle(4);
      chk("lsb_seq_1011", {16'd0, obs_l}, 32'h000D);
      chk("siso_1011", {28'd0, siso}, 32'hB);
      chk("frame_done_1011", nfd, 1);

      // Back-to-back A then 5, second load at the last-bit edge.
      clear_obs();
      cycle(1'b1, 4'hA, 1'b0);
      idle(3);
      cycle(1'b1, 4'h5, 1'b0);
      idle(4);
      chk("b2b_seq", {16'd0, obs_l}, 32'h005A);
      chk("b2b_valid_cnt", nvld, 8);
      chk("b2b_frame_done", nfd, 2);

      // MSB-first ordering.
      clear_obs();
      cycle(1'b1, 4'b1000, 1'b0);
      idle(4);
      chk("msb_seq_1000", {16'd0, obs_m}, 32'h0008);

      // load_valid held throughout a frame with different data.
      clear_obs();
      cycle(1'b1, 4'hF, 1'b0);
      for (int i = 0; i < 3; i++) cycle(1'b1, 4'h3, 1'b0);
      chk("hold_ready_hits", rdy_hits, 1);
      chk("hold_seq_F", {16'd0, obs_l}, 32'h000F);
      cycle(1'b1, 4'h3, 1'b0);
      idle(4);
      chk("hold_next_word", {16'd0, obs_l}, 32'h00FC);

      // Flush during bit 2 with a simultaneous load.
      clear_obs();
      cycle(1'b1, 4'hC, 1'b0);
      idle(2);
      cycle(1'b1, 4'h7, 1'b1);
      chk("flush_idle", {30'd0, sv_l, bz_l}, 32'd0);
      idle(1);
      clear_obs();
      cycle(1'b1, 4'h6, 1'b0);
      idle(4);
      chk("after_flush_seq", {16'd0, obs_l}, 32'h0006);

      // Asynchronous reset mid-frame, between clock edges.
      cycle(1'b1, 4'h9, 1'b0);
      idle(1);
      #2 clear_n = 1'b0;
      #1 chk("async_clear_lsb", {28'd0, sv_l, so_l, fd_l, bz_l}, 32'd0);
      chk("async_clear_msb", {28'd0, sv_m, so_m, fd_m, bz_m}, 32'd0);
      q_l.delete();
      q_m.delete();
      @(negedge clk);
      clear_n = 1'b1;
      clear_obs();
      idle(3);
      chk("post_reset_quiet", nvld, 0);
      cycle(1'b1, 4'h3, 1'b0);
      idle(4);
      chk("post_reset_seq", {16'd0, obs_l}, 32'h000C);

      // Randomized traffic.
      for (int i = 0; i < 400; i++) begin
         cycle(logic'($urandom_range(0, 9) < 6), W'($urandom), logic'($urandom_range(0, 19) == 0));
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
